// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys fetched from an external store via rk_idx.
// Latency NUM_ROUNDS cycles after acceptance; result held until out_ready, no input accepted while busy.
package aes_package;
    localparam int AES_DATA_WIDTH = 128;
endpackage

module inv_sbox (
    input  logic [7:0] addr,
    output logic [7:0] dout
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] aff;
    logic [7:0] sq;
    logic [7:0] acc;

    // Undo the affine map, then invert in GF(2^8) as x^254 (maps 0 to 0).
    always_comb begin
        aff = {addr[6:0], addr[7]} ^ {addr[4:0], addr[7:5]} ^ {addr[1:0], addr[7:2]} ^ 8'h05;
        sq  = aff;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        dout = acc;
    end
endmodule

module aes_inv_cipher_iter #(
    parameter int DATA_WIDTH = aes_package::AES_DATA_WIDTH,
    parameter int NUM_ROUNDS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] ciphertext,
    output logic [3:0]            rk_idx,
    input  logic [DATA_WIDTH-1:0] round_key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] plaintext,
    output logic                  busy
);
    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} fsm_e;

    fsm_e                  fsm_q;
    logic [DATA_WIDTH-1:0] state_q, state_d;
    logic [3:0]            rnd_q;
    logic [3:0]            rk_idx_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] subbed;
    logic [DATA_WIDTH-1:0] round_t;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // k selects which of {1,2,4,8}*b to sum, so 4'he gives 0x0e*b.
    function automatic logic [7:0] mulk(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xt(b);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? b : 8'h00);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] inv_mix(input logic [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[DATA_WIDTH-1-32*c -: 8];
            a1 = s[DATA_WIDTH-9-32*c -: 8];
            a2 = s[DATA_WIDTH-17-32*c -: 8];
            a3 = s[DATA_WIDTH-25-32*c -: 8];
            o[DATA_WIDTH-1-32*c -: 8]  = mulk(a0, 4'he) ^ mulk(a1, 4'hb) ^ mulk(a2, 4'hd) ^ mulk(a3, 4'h9);
            o[DATA_WIDTH-9-32*c -: 8]  = mulk(a0, 4'h9) ^ mulk(a1, 4'he) ^ mulk(a2, 4'hb) ^ mulk(a3, 4'hd);
            o[DATA_WIDTH-17-32*c -: 8] = mulk(a0, 4'hd) ^ mulk(a1, 4'h9) ^ mulk(a2, 4'he) ^ mulk(a3, 4'hb);
            o[DATA_WIDTH-25-32*c -: 8] = mulk(a0, 4'hb) ^ mulk(a1, 4'hd) ^ mulk(a2, 4'h9) ^ mulk(a3, 4'he);
        end
        return o;
    endfunction

    // Row r rotates right by r columns.
    always_comb begin
        shifted = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                shifted[DATA_WIDTH-1-32*c-8*r -: 8] = state_q[DATA_WIDTH-1-32*((c-r+4)%4)-8*r -: 8];
            end
        end
    end

    for (genvar g = 0; g < DATA_WIDTH/8; g++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .addr (shifted[8*g +: 8]),
            .dout (subbed[8*g +: 8])
        );
    end

    assign round_t = subbed ^ round_key;

    always_comb begin
        state_d = state_q;
        unique case (fsm_q)
            S_IDLE:  if (in_valid && in_ready_q) state_d = ciphertext ^ round_key;
            S_ROUND: state_d = (rnd_q == 4'd0) ? round_t : inv_mix(round_t);
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            rnd_q       <= 4'd0;
            rk_idx_q    <= 4'(NUM_ROUNDS);
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (fsm_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        fsm_q      <= S_ROUND;
                        rnd_q      <= 4'(NUM_ROUNDS - 1);
                        rk_idx_q   <= 4'(NUM_ROUNDS - 1);
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_ROUND: begin
                    if (rnd_q != 4'd0) begin
                        rnd_q    <= rnd_q - 4'd1;
                        rk_idx_q <= rnd_q - 4'd1;
                    end else begin
                        fsm_q       <= S_DONE;
                        out_valid_q <= 1'b1;
                        rk_idx_q    <= 4'(NUM_ROUNDS);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        fsm_q       <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign rk_idx    = rk_idx_q;
    assign plaintext = out_valid_q ? state_q : '0;
endmodule

// File: doc/aes_inv_cipher_iter.md
AES_INV_CIPHER_ITER -- requirements
Module: aes_inv_cipher_iter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128 (from aes_package), the block width in bits.
REQ-002 SHALL have parameter NUM_ROUNDS, default 10, the AES-128 round count.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  ciphertext offered.
REQ-006 SHALL have port in_ready  output  1  the core can accept a block.
REQ-007 SHALL have port ciphertext  input  DATA_WIDTH  input block.
REQ-008 SHALL have port rk_idx  output  4  index of the round key requested this cycle.
REQ-009 SHALL have port round_key  input  DATA_WIDTH  round key rk_idx, supplied combinationally in the same cycle by the external key store.
REQ-010 SHALL have port out_valid  output  1  plaintext valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts plaintext.
REQ-012 SHALL have port plaintext  output  DATA_WIDTH  decrypted block.
REQ-013 SHALL have port busy  output  1  high in ROUND or DONE.

Function
REQ-014 SHALL map byte (row r, column c) to bits [DATA_WIDTH-1-32c-8r -: 8] for ciphertext, round_key, state and plaintext, i.e. FIPS-197 column-major order.
REQ-015 SHALL implement the FSM states IDLE, ROUND and DONE, with a 128-bit state register and a 4-bit round counter rnd.
REQ-016 IDLE: in_ready=1 and rk_idx=NUM_ROUNDS; on in_valid&&in_ready, state<=ciphertext^round_key, rnd<=NUM_ROUNDS-1, and the FSM moves to ROUND.
REQ-017 ROUND: rk_idx=rnd; each cycle, t=InvSubBytes(InvShiftRows(state))^round_key.
REQ-018 ROUND with rnd>0: state<=InvMixColumns(t) and rnd<=rnd-1.
REQ-019 ROUND with rnd==0: state<=t (no InvMixColumns) and the FSM moves to DONE.
REQ-020 InvShiftRows SHALL rotate row r right by r positions: new[r][c]=old[r][(c-r) mod 4].
REQ-021 InvSubBytes SHALL use 16 instances of inv_sbox (8-bit addr in, 8-bit dout out), one per byte.
REQ-022 InvMixColumns SHALL multiply each column by circulant {0e,0b,0d,09} in GF(2^8), using xtime with reduction 0x1B; integer multiply SHALL NOT be used.
REQ-023 DONE: out_valid=1 and plaintext=state, held stable until out_valid&&out_ready; on that handshake the FSM moves to IDLE.
REQ-024 in_ready SHALL be 0 in ROUND and DONE; in_valid there SHALL be ignored, with no overlap or queuing.
REQ-025 Latency: the acceptance edge plus NUM_ROUNDS edges, so out_valid rises NUM_ROUNDS cycles after the acceptance edge; throughput is one block per NUM_ROUNDS+2 cycles with out_ready held high.
REQ-026 In IDLE, a handshake on the same edge as DONE->IDLE is impossible, since in_ready is 0 in DONE; the block is accepted on the next cycle.
REQ-027 plaintext SHALL be all-zero whenever out_valid=0.
REQ-028 rk_idx SHALL be NUM_ROUNDS in IDLE and DONE.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, state register 0, rnd 0, out_valid 0, plaintext 0, busy 0, in_ready 1 after release.
REQ-030 Reset mid-ROUND or mid-DONE SHALL discard the in-flight block, with no out_valid pulse after release.
REQ-031 Acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 FIPS-197 C.1: with the bench supplying the round keys expanded from 000102030405060708090a0b0c0d0e0f (rk[10]=13111d7fe3944a17f307a78b4d2b30c5), ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff with out_valid exactly 10 cycles after acceptance.
REQ-033 rk_idx sequence check: after acceptance, rk_idx=9,8,...,0 on consecutive cycles, then 10.
REQ-034 Backpressure: out_ready held 0 for 7 cycles in DONE -> plaintext and out_valid stable and in_ready=0 throughout; in_valid pulsed during DONE is not accepted.
REQ-035 Reset at round 5 -> out_valid and plaintext are 0 immediately, no output after release; a following C.1 block decrypts correctly.
REQ-036 Back-to-back: 3 random blocks with in_valid held high, each checked against an encrypt-then-decrypt reference model, with an acceptance spacing of 12 cycles.
